// File: rtl/multicycle_control_pkg.sv
// =============================================================================
// Module      : multicycle_control_pkg
// Description : Shared encodings for the multicycle MIPS control path.
// Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

package multicycle_control_pkg;

   // Instruction opcodes (instr[31:26])
   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_ANDI  = 6'b001100;
   localparam logic [5:0] OP_ORI   = 6'b001101;
   localparam logic [5:0] OP_SLTI  = 6'b001010;

   // ALUOp encoding shared with the ALU control block
   localparam logic [2:0] ALU_RTYPE = 3'b000;
   localparam logic [2:0] ALU_ADD   = 3'b001;
   localparam logic [2:0] ALU_SUB   = 3'b010;
   localparam logic [2:0] ALU_AND   = 3'b011;
   localparam logic [2:0] ALU_OR    = 3'b100;
   localparam logic [2:0] ALU_SLT   = 3'b101;

   localparam logic [1:0] SRCB_RT      = 2'b00;
   localparam logic [1:0] SRCB_FOUR    = 2'b01;
   localparam logic [1:0] SRCB_IMM     = 2'b10;
   localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

   localparam logic [1:0] PCSRC_ALU    = 2'b00;
   localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
   localparam logic [1:0] PCSRC_JUMP   = 2'b10;

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEM_ADDR = 4'd2,
      S_MEM_RD   = 4'd3,
      S_MEM_WB   = 4'd4,
      S_MEM_WR   = 4'd5,
      S_EXEC_R   = 4'd6,
      S_R_WB     = 4'd7,
      S_BRANCH   = 4'd8,
      S_JUMP     = 4'd9,
      S_EXEC_I   = 4'd10,
      S_I_WB     = 4'd11,
      S_TRAP     = 4'd15
   } state_e;

   function automatic logic [2:0] imm_alu_op(input logic [5:0] op);
      case (op)
         OP_ANDI: imm_alu_op = ALU_AND;
         OP_ORI:  imm_alu_op = ALU_OR;
         OP_SLTI: imm_alu_op = ALU_SLT;
         default: imm_alu_op = ALU_ADD;
      endcase
   endfunction

endpackage

`default_nettype wire

// File: rtl/multicycle_control_mem_wait_timer.sv
// =============================================================================
// Module      : mem_wait_timer
// Description : Counts memory wait cycles and flags when the limit is reached.
// Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

module mem_wait_timer #(
   parameter int WAIT_LIMIT = 16,
   parameter int CNT_W      = 5
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr_i,
   input  logic inc_i,
   output logic expired_o
);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   assign expired_o = (cnt_q == CNT_W'(WAIT_LIMIT));

   // Holds at the limit so a late mem_ready still sees expired_o steady
   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (inc_i && !expired_o) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

`default_nettype wire

// File: rtl/multicycle_control.sv
// =============================================================================
// Module      : multicycle_control
// Description : Main control FSM of the multicycle MIPS datapath.
// Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

module multicycle_control
   import multicycle_control_pkg::*;
#(
   parameter int WAIT_LIMIT = 16,
   parameter int CNT_W      = 5
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [5:0] opcode,
   input  logic       zero,
   input  logic       mem_ready,
   output logic       mem_read,
   output logic       mem_write,
   output logic       i_or_d,
   output logic       ir_write,
   output logic       pc_write,
   output logic       pc_write_cond,
   output logic [1:0] pc_source,
   output logic       alu_src_a,
   output logic [1:0] alu_src_b,
   output logic [2:0] alu_op,
   output logic       reg_write,
   output logic       reg_dst,
   output logic       mem_to_reg,
   output logic       trap,
   output logic [3:0] estado
);

   state_e     state_q;
   state_e     state_d;
   logic [5:0] op_q;
   logic [5:0] op_d;
   logic       wait_st;
   logic       expired;
   logic       unused_zero;

   // zero only matters to the datapath's conditional PC-write gate
   assign unused_zero = zero;

   mem_wait_timer #(
      .WAIT_LIMIT (WAIT_LIMIT),
      .CNT_W      (CNT_W)
   ) u_timer (
      .clk       (clk),
      .rst_n     (rst_n),
      .clr_i     (state_d != state_q),
      .inc_i     (wait_st && !mem_ready),
      .expired_o (expired)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= S_FETCH;
         op_q    <= '0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      op_d          = op_q;
      wait_st       = 1'b0;
      mem_read      = 1'b0;
      mem_write     = 1'b0;
      i_or_d        = 1'b0;
      ir_write      = 1'b0;
      pc_write      = 1'b0;
      pc_write_cond = 1'b0;
      pc_source     = PCSRC_ALU;
      alu_src_a     = 1'b0;
      alu_src_b     = SRCB_RT;
      alu_op        = ALU_RTYPE;
      reg_write     = 1'b0;
      reg_dst       = 1'b0;
      mem_to_reg    = 1'b0;
      trap          = 1'b0;
      estado        = state_q;

      case (state_q)
         S_FETCH: begin
            mem_read  = 1'b1;
            alu_src_b = SRCB_FOUR;
            alu_op    = ALU_ADD;
            wait_st   = 1'b1;
            if (mem_ready) begin
               ir_write = 1'b1;
               pc_write = 1'b1;
               state_d  = S_DECODE;
            end else if (expired) begin
               state_d = S_TRAP;
            end
         end
         S_DECODE: begin
            alu_src_b = SRCB_IMM_SH2;
            alu_op    = ALU_ADD;
            op_d      = opcode;
            case (opcode)
               OP_LW, OP_SW:                     state_d = S_MEM_ADDR;
               OP_RTYPE:                         state_d = S_EXEC_R;
               OP_BEQ:                           state_d = S_BRANCH;
               OP_J:                             state_d = S_JUMP;
               OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: state_d = S_EXEC_I;
               default:                          state_d = S_TRAP;
            endcase
         end
         S_MEM_ADDR: begin
            alu_src_a = 1'b1;
            alu_src_b = SRCB_IMM;
            alu_op    = ALU_ADD;
            state_d   = (op_q == OP_LW) ? S_MEM_RD : S_MEM_WR;
         end
         S_MEM_RD: begin
            mem_read = 1'b1;
            i_or_d   = 1'b1;
            wait_st  = 1'b1;
            if (mem_ready) begin
               state_d = S_MEM_WB;
            end else if (expired) begin
               state_d = S_TRAP;
            end
         end
         S_MEM_WB: begin
            reg_write  = 1'b1;
            mem_to_reg = 1'b1;
            state_d    = S_FETCH;
         end
         S_MEM_WR: begin
            mem_write = 1'b1;
            i_or_d    = 1'b1;
            wait_st   = 1'b1;
            if (mem_ready) begin
               state_d = S_FETCH;
            end else if (expired) begin
               state_d = S_TRAP;
            end
         end
         S_EXEC_R: begin
            alu_src_a = 1'b1;
            state_d   = S_R_WB;
         end
         S_R_WB: begin
            reg_write = 1'b1;
            reg_dst   = 1'b1;
            state_d   = S_FETCH;
         end
         S_BRANCH: begin
            alu_src_a     = 1'b1;
            alu_op        = ALU_SUB;
            pc_write_cond = 1'b1;
            pc_source     = PCSRC_ALUOUT;
            state_d       = S_FETCH;
         end
         S_JUMP: begin
            pc_write  = 1'b1;
            pc_source = PCSRC_JUMP;
            state_d   = S_FETCH;
         end
         S_EXEC_I: begin
            alu_src_a = 1'b1;
            alu_src_b = SRCB_IMM;
            alu_op    = imm_alu_op(op_q);
            state_d   = S_I_WB;
         end
         S_I_WB: begin
            reg_write = 1'b1;
            state_d   = S_FETCH;
         end
         default: begin
            // TRAP, plus unused codes 12-14 which fall into it
            trap    = (state_q == S_TRAP);
            state_d = S_TRAP;
         end
      endcase

      if (!rst_n) begin
         mem_read      = 1'b0;
         mem_write     = 1'b0;
         i_or_d        = 1'b0;
         ir_write      = 1'b0;
         pc_write      = 1'b0;
         pc_write_cond = 1'b0;
         pc_source     = PCSRC_ALU;
         alu_src_a     = 1'b0;
         alu_src_b     = SRCB_RT;
         alu_op        = ALU_ADD;
         reg_write     = 1'b0;
         reg_dst       = 1'b0;
         mem_to_reg    = 1'b0;
         trap          = 1'b0;
         estado        = 4'd0;
      end
   end

endmodule

`default_nettype wire

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Main control FSM for the multicycle MIPS datapath.
- Sequences each instruction through fetch, decode, execute, memory and writeback.
- Drives all datapath enables and muxes, plus the 3-bit ALUOp consumed by the ALU control block.
- Waits on a memory ready handshake; a watchdog traps stalled memory accesses and illegal opcodes.

Parameters:
- WAIT_LIMIT, 16: max cycles a memory access may wait for mem_ready before trapping (>=1).
- CNT_W, 5: width of the wait counter; must hold WAIT_LIMIT.

Ports:
- clk  in  1  system clock, all state updates on rising edge
- rst_n  in  1  synchronous active-low reset (sampled on rising clk)
- opcode  in  6  instr[31:26] from the instruction register
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory completes the current read/write this cycle
- mem_read  out  1  memory read request
- mem_write  out  1  memory write request
- i_or_d  out  1  address mux select: 0=PC, 1=ALUOut
- ir_write  out  1  instruction register load
- pc_write  out  1  unconditional PC load
- pc_write_cond  out  1  PC load if zero (beq)
- pc_source  out  2  00=ALU result, 01=ALUOut, 10=jump target
- alu_src_a  out  1  0=PC, 1=rs register
- alu_src_b  out  2  00=rt, 01=const 4, 10=sign-ext imm, 11=sign-ext imm<<2
- alu_op  out  3  000=R-type (use funct), 001=ADD, 010=SUB, 011=AND, 100=OR, 101=SLT
- reg_write  out  1  register file write
- reg_dst  out  1  0=rt, 1=rd
- mem_to_reg  out  1  0=ALUOut, 1=MDR
- trap  out  1  sticky fault indicator
- estado  out  4  current state encoding (debug)

Behaviour:
- Reset: rst_n=0 at a rising edge forces FETCH, clears the wait counter and clears trap. This applies mid-instruction, mid-wait and in TRAP. All outputs are 0 while rst_n=0, except alu_op=001.
- Opcodes: R=000000, lw=100011, sw=101011, beq=000100, j=000010, addi=001000, andi=001100, ori=001101, slti=001010.
- States, with unlisted outputs 0:
  - FETCH(0): mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=001. ir_write=1 and pc_write=1 only in the cycle mem_ready=1; that cycle -> DECODE, otherwise stay.
  - DECODE(1): alu_src_b=11, alu_op=001 (branch target precompute). Dispatch: lw/sw->MEM_ADDR, R->EXEC_R, beq->BRANCH, j->JUMP, addi/andi/ori/slti->EXEC_I, other->TRAP.
  - MEM_ADDR(2): alu_src_a=1, alu_src_b=10, alu_op=001. lw->MEM_RD, sw->MEM_WR.
  - MEM_RD(3): mem_read=1, i_or_d=1. Wait for mem_ready, then -> MEM_WB.
  - MEM_WB(4): reg_write=1, mem_to_reg=1, reg_dst=0 -> FETCH.
  - MEM_WR(5): mem_write=1, i_or_d=1. Wait for mem_ready, then -> FETCH.
  - EXEC_R(6): alu_src_a=1, alu_src_b=00, alu_op=000 -> R_WB.
  - R_WB(7): reg_write=1, reg_dst=1 -> FETCH.
  - BRANCH(8): alu_src_a=1, alu_src_b=00, alu_op=010, pc_write_cond=1, pc_source=01 -> FETCH.
  - JUMP(9): pc_write=1, pc_source=10 -> FETCH.
  - EXEC_I(10): alu_src_a=1, alu_src_b=10. alu_op = addi 001, andi 011, ori 100, slti 101 -> I_WB.
  - I_WB(11): reg_write=1, reg_dst=0, mem_to_reg=0 -> FETCH.
  - TRAP(15): trap=1, all enables 0; stays until reset.
- Opcode is sampled in DECODE and registered. The registered copy selects the lw/sw branch in MEM_ADDR and alu_op in EXEC_I, so opcode may change after DECODE.
- Watchdog: the counter clears on entry to FETCH/MEM_RD/MEM_WR and increments each cycle those states wait with mem_ready=0.
  - When it reaches WAIT_LIMIT with mem_ready still 0 -> TRAP.
  - mem_ready=1 in the same cycle the limit is reached wins: normal transition, no trap.
- Latency: R/addi-class 4 cycles, lw 5, sw 4, beq 3, j 3, assuming mem_ready=1 on first request.
- Outputs are decoded combinationally from state (plus mem_ready in FETCH). Unused state codes 12–14 go to TRAP.

Decomposition:
- Shared package/header: opcode constants, the ALUOp encoding (shared with the ALU control block), state encodings and the alu_src_b/pc_source select encodings.
- One natural sub-module: mem_wait_timer (counter + limit compare), instantiated once.

Test Plan:
- Reset mid-MEM_RD with mem_ready=0 -> next cycle estado=0, mem_read=1, i_or_d=0, trap=0.
- Opcode 000000, mem_ready=1 always -> estado sequence 0,1,6,7,0. alu_op=000 in state 6; reg_write=1, reg_dst=1 only in state 7.
- lw with mem_ready delayed 3 cycles in FETCH and 2 in MEM_RD -> 0x4,1,2,3x3,4,0. ir_write pulses exactly once; mem_to_reg=1 in state 4.
- beq with zero=1 -> states 0,1,8,0; in state 8 pc_write_cond=1, pc_source=01, alu_op=010.
- ori (001101) -> alu_op=100 in EXEC_I. Opcode 111111 -> DECODE then TRAP with trap=1 held 10 cycles, cleared by rst_n=0.
- mem_ready held 0 in FETCH, WAIT_LIMIT=16 -> TRAP after 16 wait cycles. Repeat with mem_ready=1 on the limit cycle -> DECODE, no trap.
